as2650_wb_mailbox: RTL and testbench

- Wishbone slave sitting between the Caravel management Wishbone (user_project_wrapper wbs_* pins) and the AS2650 core's I/O-port side.
- Two byte FIFOs: host->CPU (TX) and CPU->host (RX).
- CTRL register holds the CPU in reset and gates an interrupt to the management SoC, so firmware can load and talk to the CPU.

---
 rtl/as2650_wb_mailbox.sv | 165 ++++++++++++++++
 tb/tb_as2650_wb_mailbox.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/as2650_wb_mailbox.sv
// Wishbone mailbox between the Caravel management SoC and the AS2650 core: TX/RX byte FIFOs,
// CTRL/STATUS registers, CPU reset hold and host IRQ. Optional MAILBOX_TIMESTAMP_EN adds a cycle counter.
module as2650_wb_mailbox #(
    parameter int unsigned DEPTH    = 8,
    parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        cpu_rst_o,
    input  logic        cpu_rd_i,
    output logic [7:0]  cpu_rdata_o,
    output logic        cpu_rvalid_o,
    input  logic        cpu_wr_i,
    input  logic [7:0]  cpu_wdata_i,
    output logic        cpu_wready_o,
    output logic        irq_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [7:0]  tx_mem [DEPTH];
    logic [7:0]  rx_mem [DEPTH];
    logic [AW:0] tx_wr_q, tx_rd_q, tx_wr_d, tx_rd_d, tx_cnt;
    logic [AW:0] rx_wr_q, rx_rd_q, rx_wr_d, rx_rd_d, rx_cnt;
    logic        ack_q, hold_q, hold_d, irq_en_q, irq_en_d, cpu_rst_q, irq_q;
    logic        tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d;
    logic [31:0] dat_q, dat_d, rdata;
    logic        hit, hi, access, wr_acc, rd_acc;
    logic [1:0]  off;
    logic        tx_empty, tx_full, rx_empty, rx_full;
    logic        tx_push, tx_pop, tx_flush, tx_accept;
    logic        rx_push, rx_pop, rx_accept, sts_clr;
    logic        unused_ok;

`ifdef MAILBOX_TIMESTAMP_EN
    logic [31:0] ts_q, last_ts_q;
    assign hit = wbs_adr_i[31:5] == BASE_ADR[31:5];
    assign hi  = wbs_adr_i[4];
`else
    assign hit = wbs_adr_i[31:4] == BASE_ADR[31:4];
    assign hi  = 1'b0;
`endif

    assign unused_ok = ^{wbs_sel_i[3:1], wbs_dat_i[31:8], wbs_adr_i[1:0]};

    assign off    = wbs_adr_i[3:2];
    assign access = wbs_stb_i & wbs_cyc_i & hit & ~ack_q;
    assign wr_acc = access & wbs_we_i & ~hi;
    assign rd_acc = access & ~wbs_we_i;

    assign tx_cnt   = tx_wr_q - tx_rd_q;
    assign rx_cnt   = rx_wr_q - rx_rd_q;
    assign tx_empty = tx_wr_q == tx_rd_q;
    assign rx_empty = rx_wr_q == rx_rd_q;
    assign tx_full  = (tx_wr_q[AW] != tx_rd_q[AW]) && (tx_wr_q[AW-1:0] == tx_rd_q[AW-1:0]);
    assign rx_full  = (rx_wr_q[AW] != rx_rd_q[AW]) && (rx_wr_q[AW-1:0] == rx_rd_q[AW-1:0]);

    // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
    assign tx_flush  = wr_acc && off == 2'd0 && wbs_dat_i[2];
    assign tx_push   = wr_acc && off == 2'd2 && wbs_sel_i[0];
    assign tx_pop    = cpu_rd_i && !hold_q && !tx_empty;
    assign tx_accept = tx_push && !tx_flush && (!tx_full || tx_pop);
    assign rx_push   = cpu_wr_i && !hold_q;
    assign rx_pop    = rd_acc && !hi && off == 2'd3 && !rx_empty;
    assign rx_accept = rx_push && (!rx_full || rx_pop);
    assign sts_clr   = wr_acc && off == 2'd1;

    always_comb begin
        tx_wr_d  = tx_wr_q + (AW+1)'(tx_accept);
        tx_rd_d  = tx_rd_q + (AW+1)'(tx_pop);
        rx_wr_d  = rx_wr_q + (AW+1)'(rx_accept);
        rx_rd_d  = rx_rd_q + (AW+1)'(rx_pop);
        hold_d   = hold_q;
        irq_en_d = irq_en_q;
        if (tx_flush) begin
            tx_wr_d = '0;
            tx_rd_d = '0;
        end
        if (wr_acc && off == 2'd0) begin
            hold_d   = wbs_dat_i[0];
            irq_en_d = wbs_dat_i[1];
        end
        tx_ovf_d = (tx_ovf_q & ~sts_clr) | (tx_push && tx_full && !tx_pop && !tx_flush);
        rx_ovf_d = (rx_ovf_q & ~sts_clr) | (rx_push && rx_full && !rx_pop);
    end

    always_comb begin
        rdata = '0;
        if (!hi) begin
            case (off)
                2'd0: rdata = {30'd0, irq_en_q, hold_q};
                2'd1: rdata = {12'd0, rx_ovf_q, tx_ovf_q, rx_empty, tx_full, 8'(rx_cnt), 8'(tx_cnt)};
                2'd3: rdata = rx_empty ? '0 : {24'd0, rx_mem[rx_rd_q[AW-1:0]]};
                default: rdata = '0;
            endcase
        end
`ifdef MAILBOX_TIMESTAMP_EN
        else if (off == 2'd2) rdata = last_ts_q;
        else if (off == 2'd3) rdata = ts_q;
`endif
        dat_d = rd_acc ? rdata : '0;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ack_q     <= 1'b0;
            dat_q     <= '0;
            hold_q    <= 1'b1;
            irq_en_q  <= 1'b0;
            cpu_rst_q <= 1'b1;
            irq_q     <= 1'b0;
            tx_ovf_q  <= 1'b0;
            rx_ovf_q  <= 1'b0;
            tx_wr_q   <= '0;
            tx_rd_q   <= '0;
            rx_wr_q   <= '0;
            rx_rd_q   <= '0;
        end else begin
            ack_q     <= access;
            dat_q     <= dat_d;
            hold_q    <= hold_d;
            irq_en_q  <= irq_en_d;
            cpu_rst_q <= hold_d;
            irq_q     <= irq_en_d && (rx_wr_d != rx_rd_d);
            tx_ovf_q  <= tx_ovf_d;
            rx_ovf_q  <= rx_ovf_d;
            tx_wr_q   <= tx_wr_d;
            tx_rd_q   <= tx_rd_d;
            rx_wr_q   <= rx_wr_d;
            rx_rd_q   <= rx_rd_d;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (tx_accept) tx_mem[tx_wr_q[AW-1:0]] <= wbs_dat_i[7:0];
        if (rx_accept) rx_mem[rx_wr_q[AW-1:0]] <= cpu_wdata_i;
    end

`ifdef MAILBOX_TIMESTAMP_EN
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ts_q      <= '0;
            last_ts_q <= '0;
        end else begin
            ts_q <= ts_q + 32'd1;
            if (rx_accept) last_ts_q <= ts_q;
        end
    end
`endif

    assign wbs_ack_o    = ack_q;
    assign wbs_dat_o    = dat_q;
    assign cpu_rst_o    = cpu_rst_q;
    assign irq_o        = irq_q;
    assign cpu_rvalid_o = !tx_empty;
    assign cpu_rdata_o  = tx_empty ? '0 : tx_mem[tx_rd_q[AW-1:0]];
    assign cpu_wready_o = !rx_full;
endmodule

// File: tb/tb_as2650_wb_mailbox.sv
// Bench for as2650_wb_mailbox: queue-based reference model, directed scenarios plus random traffic.
module tb_as2650_wb_mailbox;
    localparam int DEPTH = 8;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'hF;
    logic [31:0] adr = BASE, dat = '0;
    logic        rd = 1'b0, wr = 1'b0;
    logic [7:0]  wd = '0;
    logic [31:0] wbs_dat_o;
    logic        wbs_ack_o, cpu_rst_o, cpu_rvalid_o, cpu_wready_o, irq_o;
    logic [7:0]  cpu_rdata_o;

    int errors = 0, checks = 0;

    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    bit m_hold, m_irqen, m_txovf, m_rxovf, m_ack;
    logic [31:0] m_dat;

    as2650_wb_mailbox #(.DEPTH(DEPTH), .BASE_ADR(BASE)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o),
        .cpu_rst_o(cpu_rst_o), .cpu_rd_i(rd), .cpu_rdata_o(cpu_rdata_o), .cpu_rvalid_o(cpu_rvalid_o),
        .cpu_wr_i(wr), .cpu_wdata_i(wd), .cpu_wready_o(cpu_wready_o), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        txq.delete(); rxq.delete();
        m_hold = 1; m_irqen = 0; m_txovf = 0; m_rxovf = 0; m_ack = 0; m_dat = '0;
    endtask

    function automatic logic [31:0] m_status();
        return {12'd0, m_rxovf, m_txovf, rxq.size() == 0, txq.size() == DEPTH,
                8'(rxq.size()), 8'(txq.size())};
    endfunction

    // One clock: apply the held inputs to the model at the edge, then compare all outputs.
    task automatic step();
        bit acc, hold0, full, txpop, rxpop, txpush, rxpush, flush, clr;
        logic [31:0] rv;
        @(posedge clk);
        acc = stb && cyc && (adr[31:4] == BASE[31:4]) && !m_ack;
        hold0 = m_hold; rv = '0;
        flush = 0; clr = 0; txpush = 0; rxpop = 0;
        if (acc && we) begin
            case (adr[3:2])
                2'd0: begin flush = dat[2]; m_hold = dat[0]; m_irqen = dat[1]; end
                2'd1: clr = 1;
                2'd2: txpush = sel[0];
                default: ;
            endcase
        end else if (acc) begin
            case (adr[3:2])
                2'd0: rv = {30'd0, m_irqen, hold0};
                2'd1: rv = m_status();
                2'd3: if (rxq.size() > 0) begin rv = {24'd0, rxq[0]}; rxpop = 1; end
                default: rv = '0;
            endcase
        end
        if (clr) begin m_txovf = 0; m_rxovf = 0; end
        txpop = rd && !hold0 && txq.size() > 0;
        if (flush) txq.delete();
        else begin
            full = txq.size() == DEPTH;
            if (txpop) void'(txq.pop_front());
            if (txpush) begin
                if (!full || txpop) txq.push_back(dat[7:0]);
                else m_txovf = 1;
            end
        end
        rxpush = wr && !hold0;
        full = rxq.size() == DEPTH;
        if (rxpop) void'(rxq.pop_front());
        if (rxpush) begin
            if (!full || rxpop) rxq.push_back(wd);
            else m_rxovf = 1;
        end
        m_ack = acc;
        m_dat = (acc && !we) ? rv : '0;
        #1;
        check_eq("ack", wbs_ack_o, m_ack);
        check_eq("dat", wbs_dat_o, m_dat);
        check_eq("rvalid", cpu_rvalid_o, txq.size() != 0);
        check_eq("rdata", cpu_rdata_o, txq.size() != 0 ? txq[0] : 8'h00);
        check_eq("wready", cpu_wready_o, rxq.size() < DEPTH);
        check_eq("cpu_rst", cpu_rst_o, m_hold);
        check_eq("irq", irq_o, m_irqen && rxq.size() != 0);
    endtask

    task automatic wb_acc(input bit w, input logic [3:0] a, input logic [31:0] d, output logic [31:0] r);
        stb = 1; cyc = 1; we = w; adr = BASE + {26'd0, a, 2'b00}; dat = d; sel = 4'hF;
        step();
        r = wbs_dat_o;
        check_eq("ack_lat", wbs_ack_o, 1'b1);
        stb = 0; cyc = 0; we = 0;
        step();
        check_eq("ack_1cyc", wbs_ack_o, 1'b0);
    endtask

    initial begin
        logic [31:0] r;
        model_reset();
        #12 rst_n = 1;
        step();
        check_eq("rst_cpu_rst", cpu_rst_o, 1'b1);
        check_eq("rst_irq", irq_o, 1'b0);
        check_eq("rst_wready", cpu_wready_o, 1'b1);
        wb_acc(0, 4'd0, '0, r); check_eq("rst_ctrl", r, 32'h1);
        wb_acc(0, 4'd1, '0, r); check_eq("rst_status", r, 32'h0002_0000);

        // basic TX push / CPU pop
        wb_acc(1, 4'd0, 32'h0, r);
        wb_acc(1, 4'd2, 32'hA5, r);
        wb_acc(1, 4'd2, 32'h3C, r);
        check_eq("tx_head0", cpu_rdata_o, 8'hA5);
        rd = 1; step(); rd = 0;
        check_eq("tx_head1", cpu_rdata_o, 8'h3C);
        rd = 1; step(); rd = 0;
        check_eq("tx_empty", cpu_rvalid_o, 1'b0);

        // TX overflow and sticky clear
        for (int i = 0; i < 9; i++) wb_acc(1, 4'd2, 32'h50 + i, r);
        wb_acc(0, 4'd1, '0, r); check_eq("tx_ovf_status", r, 32'h0007_0008);
        wb_acc(1, 4'd1, 32'h0, r);
        wb_acc(0, 4'd1, '0, r); check_eq("tx_ovf_clr", r, 32'h0003_0008);

        // full TX: simultaneous push and pop
        stb = 1; cyc = 1; we = 1; adr = BASE + 32'h8; dat = 32'hEE; rd = 1;
        step();
        stb = 0; cyc = 0; we = 0; rd = 0;
        step();
        wb_acc(0, 4'd1, '0, r); check_eq("full_pushpop", r, 32'h0003_0008);
        check_eq("full_head", cpu_rdata_o, 8'h51);
        rd = 1;
        for (int i = 0; i < 8; i++) step();
        rd = 0;

        // RX path and irq
        wb_acc(1, 4'd0, 32'h2, r);
        wr = 1; wd = 8'h11; step(); wr = 0;
        check_eq("irq_set", irq_o, 1'b1);
        wb_acc(0, 4'd3, '0, r); check_eq("rx_read", r, 32'h11);
        check_eq("irq_clr", irq_o, 1'b0);
        wb_acc(0, 4'd3, '0, r); check_eq("rx_empty_read", r, 32'h0);
        wb_acc(0, 4'd1, '0, r); check_eq("rx_cnt0", r, 32'h0002_0000);

        // RX overflow, then hold blocks CPU ops
        wr = 1;
        for (int i = 0; i < 9; i++) begin wd = 8'(8'h20 + i); step(); end
        wr = 0;
        wb_acc(0, 4'd1, '0, r); check_eq("rx_ovf_status", r, 32'h0008_0800);
        wb_acc(1, 4'd0, 32'h3, r);
        wb_acc(1, 4'd2, 32'h77, r);
        rd = 1; wr = 1; step(); step(); rd = 0; wr = 0;
        check_eq("hold_keep", cpu_rdata_o, 8'h77);
        wb_acc(1, 4'd0, 32'h4, r);
        check_eq("flush", cpu_rvalid_o, 1'b0);

        // random traffic
        for (int n = 0; n < 1500; n++) begin
            int o;
            o = $urandom_range(0, 3);
            stb = ($urandom % 3) == 0;
            cyc = ($urandom % 8) != 0;
            we = $urandom % 2;
            case ($urandom % 12)
                0: adr = BASE + 32'h40;
                1: adr = BASE + 32'h18;
                default: adr = BASE + 32'(o * 4);
            endcase
            dat = $urandom;
            if (o == 0) begin
                dat[0] = ($urandom % 5) == 0;
                dat[2] = ($urandom % 8) == 0;
            end
            sel = 4'($urandom);
            rd = $urandom % 2;
            wr = $urandom % 2;
            wd = 8'($urandom);
            step();
        end
        stb = 0; cyc = 0; rd = 0; wr = 0;
        step();

        // async reset during an un-acked access
        wb_acc(1, 4'd0, 32'h0, r);
        wb_acc(1, 4'd2, 32'h99, r);
        stb = 1; cyc = 1; we = 0; adr = BASE;
        #2 rst_n = 0;
        #1;
        model_reset();
        check_eq("arst_ack", wbs_ack_o, 1'b0);
        check_eq("arst_cpu_rst", cpu_rst_o, 1'b1);
        check_eq("arst_rvalid", cpu_rvalid_o, 1'b0);
        @(posedge clk); #1;
        check_eq("arst_ack_hold", wbs_ack_o, 1'b0);
        stb = 0; cyc = 0;
        @(negedge clk) rst_n = 1;
        step();
        wb_acc(0, 4'd1, '0, r); check_eq("arst_status", r, 32'h0002_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
